uart_alu_host: RTL and testbench

//  Host-side initiator for the UART ALU: the far end of the link that issues commands to it.
//  On start it serialises three command bytes (A, B, op) onto tx.
//  It then waits for the single result byte on rx and hands it back with done.

---
 rtl/uart_alu_host_pkg.sv | 33 +++
 rtl/uart_alu_host_rx.sv | 112 +++++++++++
 rtl/uart_alu_host.sv | 181 ++++++++++++++++++
 tb/tb_uart_alu_host.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_host_pkg.sv
// Shared constants and state encodings for the UART ALU host initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_alu_host_pkg;

  localparam int OVERSAMPLE  = 16;  // s_ticks per serial bit
  localparam int MID_TICK    = 7;   // start-bit sample point after the falling edge
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_SEND_OP,
    ST_WAIT_RESP,
    ST_RECV
  } host_state_t;

  typedef enum logic [1:0] {
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_phase_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_alu_host_rx.sv
// Response receiver: synchronises rx, finds the start bit, samples data LSB first and the stop bit.
// Latency: strobes fire combinationally on the s_tick that samples the start/stop bit.
// Backpressure: none; disabled (held idle) whenever en is low.
module uart_alu_host_rx
  import uart_alu_host_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            en,
  input  logic            rx,
  output logic            start_det,
  output logic            glitch,
  output logic [DBIT-1:0] rx_byte,
  output logic            byte_valid,
  output logic            stop_err
);

  localparam int RTW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DBIT);
  localparam logic [RTW-1:0] BIT_LAST = RTW'(OVERSAMPLE - 1);
  localparam logic [RTW-1:0] MID      = RTW'(MID_TICK);
  localparam logic [BW-1:0]  LAST_BIT = BW'(DBIT - 1);

  rx_state_t       st;
  logic            sync1, sync2, prev;
  logic            fall, at_last;
  logic [RTW-1:0]  tick;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] sh;

  // Two-flop synchroniser plus one history flop for edge detection; line idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall    = prev & ~sync2;
  assign at_last = s_tick & (tick == BIT_LAST);
  assign rx_byte = sh;

  // Event strobes seen by the host FSM in the cycle the sample is taken.
  always_comb begin
    start_det  = en & (st == RX_IDLE) & fall;
    glitch     = en & (st == RX_START) & s_tick & (tick == MID) & sync2;
    byte_valid = en & (st == RX_STOP) & at_last & sync2;
    stop_err   = en & (st == RX_STOP) & at_last & ~sync2;
  end

  // Frame sampler: mid-start check, then one sample every OVERSAMPLE ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= RX_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      sh      <= '0;
    end else if (!en) begin
      st      <= RX_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
    end else begin
      case (st)
        RX_IDLE: begin
          if (fall) begin
            st   <= RX_START;
            tick <= '0;
          end
        end
        RX_START: begin
          if (s_tick) begin
            if (tick == MID) begin
              tick    <= '0;
              bit_cnt <= '0;
              st      <= sync2 ? RX_IDLE : RX_DATA;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (s_tick) begin
            if (tick == BIT_LAST) begin
              tick <= '0;
              sh   <= {sync2, sh[DBIT-1:1]};
              if (bit_cnt == LAST_BIT) st <= RX_STOP;
              else                     bit_cnt <= bit_cnt + 1'b1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (s_tick) begin
            if (tick == BIT_LAST) st   <= RX_IDLE;
            else                  tick <= tick + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_alu_host.sv
// Host initiator: on start sends A, B, op as back-to-back UART frames, then waits for one result byte.
// Latency: 3 frames out plus one frame back; done/timeout/frame_err pulse the clk after the deciding sample.
// Backpressure: start is only accepted in IDLE (busy=0); requests while busy are dropped.
module uart_alu_host
  import uart_alu_host_pkg::*;
#(
  parameter int DBIT     = DBIT_DEF,
  parameter int SB_TICK  = SB_TICK_DEF,
  parameter int OP_W     = 6,
  parameter int TO_TICKS = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            start,
  input  logic [DBIT-1:0] a_in,
  input  logic [DBIT-1:0] b_in,
  input  logic [OP_W-1:0] op_in,
  input  logic            rx,
  output logic            tx,
  output logic            busy,
  output logic [DBIT-1:0] result,
  output logic            done,
  output logic            timeout,
  output logic            frame_err
);

  localparam int TW  = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DBIT);
  localparam int TOW = $clog2(TO_TICKS + 1);
  localparam logic [TW-1:0]  BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]  STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DBIT - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TO_TICKS - 1);

  host_state_t     state, state_nxt;
  tx_phase_t       phase;
  logic [TW-1:0]   tick;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] tx_sh, b_q, op_ext;
  logic [OP_W-1:0] op_q;
  logic [TOW-1:0]  to_cnt;
  logic            sending, rx_en, tx_nxt, frame_end, to_hit;
  logic            start_det, glitch, byte_valid, stop_err;
  logic [DBIT-1:0] rx_byte;

  assign op_ext    = {{(DBIT-OP_W){1'b0}}, op_q};
  assign frame_end = sending & s_tick & (phase == TX_STOP) & (tick == STOP_LAST);
  assign to_hit    = (state == ST_WAIT_RESP) & s_tick & (to_cnt >= TO_LAST);

  uart_alu_host_rx #(.DBIT(DBIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .s_tick     (s_tick),
    .en         (rx_en),
    .rx         (rx),
    .start_det  (start_det),
    .glitch     (glitch),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .stop_err   (stop_err)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a response edge beats a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start)     state_nxt = ST_SEND_A;
      ST_SEND_A:    if (frame_end) state_nxt = ST_SEND_B;
      ST_SEND_B:    if (frame_end) state_nxt = ST_SEND_OP;
      ST_SEND_OP:   if (frame_end) state_nxt = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (start_det)   state_nxt = ST_RECV;
        else if (to_hit) state_nxt = ST_IDLE;
      end
      ST_RECV: begin
        if (glitch)                     state_nxt = ST_WAIT_RESP;
        else if (byte_valid | stop_err) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: busy, receiver enable and the next tx line level.
  always_comb begin
    busy    = (state != ST_IDLE);
    rx_en   = (state == ST_WAIT_RESP) | (state == ST_RECV);
    sending = (state == ST_SEND_A) | (state == ST_SEND_B) | (state == ST_SEND_OP);
    tx_nxt  = 1'b1;
    if (sending) begin
      case (phase)
        TX_START: tx_nxt = 1'b0;
        TX_DATA:  tx_nxt = tx_sh[0];
        default:  tx_nxt = 1'b1;
      endcase
    end
  end

  // TX sequencing: latch the command in IDLE, then walk start/data/stop per frame on s_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase   <= TX_START;
      tick    <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else if (state == ST_IDLE) begin
      phase   <= TX_START;
      tick    <= '0;
      bit_cnt <= '0;
      if (start) begin
        tx_sh <= a_in;
        b_q   <= b_in;
        op_q  <= op_in;
      end
    end else if (sending && s_tick) begin
      case (phase)
        TX_START: begin
          if (tick == BIT_LAST) begin
            tick    <= '0;
            bit_cnt <= '0;
            phase   <= TX_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        TX_DATA: begin
          if (tick == BIT_LAST) begin
            tick  <= '0;
            tx_sh <= tx_sh >> 1;
            if (bit_cnt == LAST_BIT) phase   <= TX_STOP;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          if (tick == STOP_LAST) begin
            tick  <= '0;
            phase <= TX_START;
            tx_sh <= (state == ST_SEND_A) ? b_q : op_ext;
          end else begin
            tick <= tick + 1'b1;
          end
        end
      endcase
    end
  end

  // Response timeout: cleared outside the receive window, held in RECV so a glitch does not restart it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   to_cnt <= '0;
    else if (!rx_en)                              to_cnt <= '0;
    else if (state == ST_WAIT_RESP && s_tick)     to_cnt <= to_cnt + 1'b1;
  end

  // Registered line driver, result capture and single-cycle completion pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx        <= 1'b1;
      result    <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx        <= tx_nxt;
      done      <= (state == ST_RECV) & byte_valid;
      frame_err <= (state == ST_RECV) & stop_err;
      timeout   <= to_hit & ~start_det;
      if ((state == ST_RECV) && byte_valid) result <= rx_byte;
    end
  end

endmodule

// File: tb/tb_uart_alu_host.sv
// Directed bench for uart_alu_host: decodes tx frames, plays the ALU reply on rx.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_alu_host;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       start = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic [5:0] op_in = 6'h00;
  logic       tx, busy, done, timeout, frame_err;
  logic [7:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;
  int done_cnt = 0;
  int to_pulses = 0;
  int fe_cnt = 0;
  int to_tick = 0;
  logic busy_at_pulse = 1'b1;

  logic [7:0] f0, f1, f2, fa;
  bit         fok, aok;
  int         g0, g1, g2, op_edge, ga, ea;
  int         d0, t0, e0, n;

  uart_alu_host #(.DBIT(8), .SB_TICK(16), .OP_W(6), .TO_TICKS(4096)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_in     (op_in),
    .rx        (rx),
    .tx        (tx),
    .busy      (busy),
    .result    (result),
    .done      (done),
    .timeout   (timeout),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // One-clk s_tick every 4 clks.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  // Count consumed ticks and every high cycle of each pulse output.
  always @(posedge clk) begin
    if (s_tick) tick_cnt++;
    if (done) begin done_cnt++; busy_at_pulse = busy; end
    if (timeout) begin to_pulses++; to_tick = tick_cnt; busy_at_pulse = busy; end
    if (frame_err) begin fe_cnt++; busy_at_pulse = busy; end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      do @(negedge clk); while (s_tick !== 1'b1);
    end
  endtask

  // Decode one frame from tx at mid-bit; returns clks spent waiting for the start edge.
  task automatic tx_get(output logic [7:0] b, output bit ok, output int gap, output int edge_tick);
    int w;
    w = 0;
    ok = 1'b1;
    b = 8'h00;
    while (tx !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    gap = w;
    edge_tick = tick_cnt;
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    wait_ticks(8);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_ticks(16);
      b[i] = tx;
    end
    wait_ticks(16);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  // Three command frames, then let the host reach WAIT_RESP.
  task automatic get3();
    bit k0, k1, k2;
    int e;
    tx_get(f0, k0, g0, e);
    tx_get(f1, k1, g1, e);
    tx_get(f2, k2, g2, op_edge);
    fok = k0 & k1 & k2;
    wait_ticks(10);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stopb);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stopb;
    wait_ticks(16);
    rx = 1'b1;
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    @(negedge clk);
    a_in = a;
    b_in = b;
    op_in = op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 1: normal transaction
    pulse_start(8'h05, 8'h03, 6'b100000);
    chk("t1_busy", busy, 1);
    get3();
    chk("t1_ok", fok, 1);
    chk("t1_a", f0, 8'h05);
    chk("t1_b", f1, 8'h03);
    chk("t1_op", f2, 8'h20);
    chk("t1_b2b_b", g1 <= 36, 1);
    chk("t1_b2b_op", g2 <= 36, 1);
    d0 = done_cnt; e0 = fe_cnt;
    send_rx(8'h08, 1'b1);
    repeat (8) @(negedge clk);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_result", result, 8'h08);
    chk("t1_busy_end", busy, 0);
    chk("t1_busy_at_done", busy_at_pulse, 0);
    chk("t1_no_ferr", fe_cnt - e0, 0);

    // 2: no reply -> timeout
    t0 = to_pulses; d0 = done_cnt;
    pulse_start(8'h05, 8'h03, 6'b100000);
    get3();
    n = 0;
    while (to_pulses == t0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("t2_timeout", to_pulses - t0, 1);
    chk("t2_to_ticks", to_tick - op_edge, 160 + 4096);
    chk("t2_result", result, 8'h08);
    chk("t2_busy", busy, 0);
    chk("t2_busy_at_to", busy_at_pulse, 0);
    chk("t2_no_done", done_cnt - d0, 0);

    // 3: bad stop bit
    pulse_start(8'h07, 8'h01, 6'h02);
    chk("t3_accept", busy, 1);
    get3();
    d0 = done_cnt; e0 = fe_cnt;
    send_rx(8'hFA, 1'b0);
    repeat (8) @(negedge clk);
    chk("t3_ferr", fe_cnt - e0, 1);
    chk("t3_no_done", done_cnt - d0, 0);
    chk("t3_result", result, 8'h08);
    chk("t3_busy", busy, 0);

    // 4: short glitch, then a good reply
    pulse_start(8'h05, 8'h03, 6'b100000);
    get3();
    d0 = done_cnt; e0 = fe_cnt;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(24);
    chk("t4_glitch_busy", busy, 1);
    chk("t4_glitch_no_done", done_cnt - d0, 0);
    send_rx(8'h3C, 1'b1);
    repeat (8) @(negedge clk);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_result", result, 8'h3C);
    chk("t4_no_ferr", fe_cnt - e0, 0);

    // 5: start re-pulsed during SEND_B is ignored
    pulse_start(8'h11, 8'h22, 6'h05);
    fork
      get3();
      begin
        wait_ticks(200);
        pulse_start(8'hAA, 8'hBB, 6'h3F);
      end
    join
    chk("t5_ok", fok, 1);
    chk("t5_a", f0, 8'h11);
    chk("t5_b", f1, 8'h22);
    chk("t5_op", f2, 8'h05);
    d0 = done_cnt;
    send_rx(8'h33, 1'b1);
    repeat (8) @(negedge clk);
    chk("t5_done", done_cnt - d0, 1);
    chk("t5_result", result, 8'h33);

    // 6: async reset in the middle of a B data bit
    pulse_start(8'hC3, 8'h5A, 6'h01);
    tx_get(fa, aok, ga, ea);
    chk("t6_a", fa, 8'hC3);
    wait_ticks(64);
    chk("t6_pre_tx", tx, 0);
    chk("t6_pre_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_tx", tx, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    pulse_start(8'h96, 8'h01, 6'h01);
    tx_get(fa, aok, ga, ea);
    chk("t6_clean_ok", aok, 1);
    chk("t6_clean_a", fa, 8'h96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
